ct_ct_sub: RTL and testbench
============================

Name: ct_ct_sub

Overview:
- Homomorphic ciphertext subtraction: ct_out = ct_1 - ct_2, computed per coefficient as (c0_1 - c0_2) mod q_k and (c1_1 - c1_2) mod q_k over all K RNS limbs.
- Sits beside ct_ct_add in the cloud ops and uses the same start/done level handshake.
- One shared read-address stream drives all four input memories; one shared write stream drives both output memories.
- Both ciphertext components are processed in lockstep, one coefficient per cycle.

Parameters:
- N, `N, polynomial degree (coefficients per limb).
- K, `K, number of RNS limbs.
- W, 32, coefficient width; every q_k < 2^W.
- AW, $clog2(N*K), memory address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  level request; a rise in IDLE launches one operation
- rd_addr  out  AW  shared read address to c0_1, c1_1, c0_2, c1_2 memories
- c0_1_rdata  in  W  c0 of ct_1, valid 1 cycle after rd_addr
- c1_1_rdata  in  W  c1 of ct_1
- c0_2_rdata  in  W  c0 of ct_2
- c1_2_rdata  in  W  c1 of ct_2
- wr_addr  out  AW  shared write address to c0_out, c1_out memories
- wr_en  out  1  write strobe for both output memories
- c0_wdata  out  W  (c0_1 - c0_2) mod q_k
- c1_wdata  out  W  (c1_1 - c1_2) mod q_k
- done  out  1  completion flag, held until start is low

Behaviour:
- Memory layout: address = k*N + i, with limb k in [0,K) and coefficient i in [0,N). Let M = N*K.
- Reset values: rd_addr=0, wr_addr=0, wr_en=0, c0_wdata=0, c1_wdata=0, done=0. The FSM goes to IDLE and all counters clear.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 at an edge E0 moves to RUN and clears the counters.
- RUN:
  - Cycle j after E0 (j=0..M-1) drives rd_addr=j.
  - A coefficient counter wraps at N-1 and increments the limb counter; no divider is used.
  - The limb index is pipelined alongside the data to select q_k.
  - After rd_addr=M-1 is issued, move to DRAIN.
- DRAIN: lasts 2 cycles, until the last write has been issued, then move to DONE.
- Data path:
  - Read data for address j arrives in cycle j+1.
  - The subtract result is registered, so wr_en=1 with wr_addr=j in cycle j+2.
  - wr_en is contiguous for M cycles, addresses 0..M-1 in ascending order, never repeated.
- Arithmetic:
  - d = a - b computed at W+1 bits.
  - If a < b, output d + q_k; otherwise output d.
  - Result is in [0, q_k). Inputs must already be < q_k; the block does not check this.
- DONE:
  - done=1 is first visible in cycle M+2 after E0 and stays high while start=1.
  - When start=0 is sampled, go to IDLE; done=0 the next cycle.
  - No relaunch occurs until start has been low in IDLE.
- start dropping during RUN or DRAIN is ignored: the operation completes, done pulses at least one cycle, then the FSM returns to IDLE.
- reset mid-operation:
  - The next cycle has wr_en=0 and done=0, the FSM is in IDLE, and no further writes occur.
  - Output memory contents are partial and undefined.
- wr_en=0 in IDLE and DONE. rd_addr holds its last value outside RUN.

Decomposition:
- Package ct_ops_pkg:
  - Q_LIMB[K] modulus constants.
  - ct_sub_state_t enum {IDLE, RUN, DRAIN, DONE}.
  - Address-width helper function.
- Sub-module mod_sub:
  - One registered stage: inputs a, b, q; output (a-b) mod q.
  - Two instances, one for c0 and one for c1.
- Top level holds the FSM, the counters, and the limb/valid/address pipeline registers.

Test Plan:
All scenarios use N=4, K=2 (M=8), Q_LIMB={17,97}, and a 1-cycle read-latency memory model.
- Limb 0 addr 0: a=5, b=3 (c0 and c1) -> wr_addr=0, c0_wdata=c1_wdata=2.
- Underflow wrap:
  - Limb 0, a=3, b=5 -> 15.
  - Limb 1 addr 4, a=0, b=96 -> 1 (checks q_k selection at the limb boundary).
- Edge values:
  - Limb 0, a=b=16 -> 0.
  - Limb 0, a=16, b=0 -> 16.
  - Limb 1, a=96, b=0 -> 96.
- Timing:
  - start at E0 -> rd_addr 0..7 in cycles 0..7.
  - wr_en high in cycles 2..9 with wr_addr 0..7.
  - done first high in cycle 10.
  - Exactly 8 writes.
- Reset asserted in RUN cycle 3 -> wr_en=0 and done=0 the next cycle, FSM in IDLE. A new start then completes all 8 writes with correct data.
- Handshake:
  - start held high 20 cycles past done -> done stays 1, no extra wr_en.
  - Drop start -> done=0 one cycle later.
  - start dropped in RUN cycle 1 -> still 8 writes and a done pulse.

Source files
------------

// File: rtl/ct_ops_pkg.sv
// Shared types and constants for the ciphertext cloud ops: RNS moduli, FSM states, width helper.
package ct_ops_pkg;

   localparam int N_DEF = 4;
   localparam int K_DEF = 2;
   localparam int W_DEF = 32;

   // One modulus per RNS limb; every entry must be below 2^W_DEF.
   localparam logic [W_DEF-1:0] Q_LIMB [K_DEF] = '{32'd17, 32'd97};

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } ct_sub_state_t;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ct_ct_sub_if.sv
// Start/done handshake plus shared read and write memory streams of ct_ct_sub.
// master = the subtract engine, slave = memories and the launching controller.
interface ct_ct_sub_if #(
   parameter int W  = 32,
   parameter int AW = 3
);
   logic          start;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  c0_1_rdata;
   logic [W-1:0]  c1_1_rdata;
   logic [W-1:0]  c0_2_rdata;
   logic [W-1:0]  c1_2_rdata;
   logic [AW-1:0] wr_addr;
   logic          wr_en;
   logic [W-1:0]  c0_wdata;
   logic [W-1:0]  c1_wdata;
   logic          done;

   modport master (
      input  start, c0_1_rdata, c1_1_rdata, c0_2_rdata, c1_2_rdata,
      output rd_addr, wr_addr, wr_en, c0_wdata, c1_wdata, done
   );

   modport slave (
      output start, c0_1_rdata, c1_1_rdata, c0_2_rdata, c1_2_rdata,
      input  rd_addr, wr_addr, wr_en, c0_wdata, c1_wdata, done
   );
endinterface

// File: rtl/ct_ct_sub_mod_sub.sv
// Registered modular subtract y = (a - b) mod q for inputs already below q.
// Latency 1 cycle; no backpressure, a new operand pair is accepted every cycle.
module mod_sub #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] q,
   output logic [W-1:0] y
);

   logic [W:0]   diff;
   logic [W-1:0] diff_wrap;

   // The extra top bit of the W+1 bit difference is the borrow, i.e. a < b.
   assign diff      = {1'b0, a} - {1'b0, b};
   assign diff_wrap = diff[W-1:0] + q;

   always_ff @(posedge clk) begin
      if (reset) begin
         y <= '0;
      end else begin
         y <= diff[W] ? diff_wrap : diff[W-1:0];
      end
   end

endmodule

// File: rtl/ct_ct_sub.sv
// Ciphertext subtract ct_1 - ct_2 over all N*K coefficients, both components in lockstep.
// Latency 2 cycles read-to-write, one coefficient per cycle; no backpressure, start/done level handshake.
module ct_ct_sub
   import ct_ops_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int K  = K_DEF,
   parameter int W  = W_DEF,
   parameter int AW = addr_width(N * K)
) (
   input logic         clk,
   input logic         reset,
   ct_ct_sub_if.master bus
);

   localparam int M  = N * K;
   localparam int CW = addr_width(N);
   localparam int LW = addr_width(K);

   ct_sub_state_t state, state_nxt;

   logic [AW-1:0] rd_addr_r;
   logic [CW-1:0] coef_cnt;
   logic [LW-1:0] limb_cnt;
   logic          drain_cnt;
   logic          last_rd;

   logic          rd_vld_q;
   logic [LW-1:0] limb_q;
   logic [AW-1:0] addr_q;
   logic          wr_en_q;
   logic [AW-1:0] wr_addr_q;

   assign last_rd = (rd_addr_r == AW'(M - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      bus.done  = 1'b0;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last_rd) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt) state_nxt = DONE;
         DONE: begin
            bus.done = 1'b1;
            if (!bus.start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Coefficient counter rolls into the limb counter so the limb is known without dividing the address.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_addr_r <= '0;
         coef_cnt  <= '0;
         limb_cnt  <= '0;
         drain_cnt <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         rd_addr_r <= '0;
         coef_cnt  <= '0;
         limb_cnt  <= '0;
         drain_cnt <= 1'b0;
      end else if (state == RUN && !last_rd) begin
         rd_addr_r <= rd_addr_r + AW'(1);
         if (coef_cnt == CW'(N - 1)) begin
            coef_cnt <= '0;
            limb_cnt <= limb_cnt + LW'(1);
         end else begin
            coef_cnt <= coef_cnt + CW'(1);
         end
      end else if (state == DRAIN) begin
         drain_cnt <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_vld_q  <= 1'b0;
         limb_q    <= '0;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
      end else begin
         rd_vld_q  <= (state == RUN);
         limb_q    <= limb_cnt;
         addr_q    <= rd_addr_r;
         wr_en_q   <= rd_vld_q;
         wr_addr_q <= addr_q;
      end
   end

   mod_sub #(.W(W)) u_sub_c0 (
      .clk   (clk),
      .reset (reset),
      .a     (bus.c0_1_rdata),
      .b     (bus.c0_2_rdata),
      .q     (Q_LIMB[limb_q]),
      .y     (bus.c0_wdata)
   );

   mod_sub #(.W(W)) u_sub_c1 (
      .clk   (clk),
      .reset (reset),
      .a     (bus.c1_1_rdata),
      .b     (bus.c1_2_rdata),
      .q     (Q_LIMB[limb_q]),
      .y     (bus.c1_wdata)
   );

   assign bus.rd_addr = rd_addr_r;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;

endmodule

// File: tb/tb_ct_ct_sub.sv
// Self-checking bench for ct_ct_sub: N=4, K=2, moduli {17,97}, 1-cycle read-latency memories.
module tb_ct_ct_sub;
   import ct_ops_pkg::*;

   localparam int N = 4;
   localparam int K = 2;
   localparam int M = N * K;

   int q_tab [K] = '{17, 97};

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   nchk = 0;
   int   nerr = 0;

   logic [31:0] m01 [M];
   logic [31:0] m11 [M];
   logic [31:0] m02 [M];
   logic [31:0] m12 [M];

   ct_ct_sub_if #(.W(32), .AW(3)) bus ();

   ct_ct_sub #(.N(N), .K(K), .W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      bus.c0_1_rdata <= m01[bus.rd_addr];
      bus.c1_1_rdata <= m11[bus.rd_addr];
      bus.c0_2_rdata <= m02[bus.rd_addr];
      bus.c1_2_rdata <= m12[bus.rd_addr];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_sub(input int a, input int b, input int idx);
      int q;
      q = q_tab[idx / N];
      return (a + q - b) % q;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < M; i++) begin
         m01[i] = 32'($urandom % q_tab[i / N]);
         m11[i] = 32'($urandom % q_tab[i / N]);
         m02[i] = 32'($urandom % q_tab[i / N]);
         m12[i] = 32'($urandom % q_tab[i / N]);
      end
   endtask

   // drop_at < 0 keeps start high through DONE for 'hold' extra cycles.
   task automatic run_op(input string name, input int drop_at, input int hold);
      int  nwr;
      int  idx;
      logic exp_done;
      nwr = 0;
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      for (int j = 0; j < M + 3 + hold; j++) begin
         @(negedge clk);
         if (j == drop_at) bus.start = 1'b0;
         if (j < M) check($sformatf("%s rd_addr c%0d", name, j), 64'(bus.rd_addr), 64'(j));
         check($sformatf("%s wr_en c%0d", name, j), 64'(bus.wr_en), 64'(j >= 2 && j < M + 2));
         if (bus.wr_en) begin
            nwr++;
            idx = j - 2;
            if (idx >= 0 && idx < M) begin
               check($sformatf("%s wr_addr c%0d", name, j), 64'(bus.wr_addr), 64'(idx));
               check($sformatf("%s c0 a%0d", name, idx), 64'(bus.c0_wdata),
                     64'(ref_sub(int'(m01[idx]), int'(m02[idx]), idx)));
               check($sformatf("%s c1 a%0d", name, idx), 64'(bus.c1_wdata),
                     64'(ref_sub(int'(m11[idx]), int'(m12[idx]), idx)));
            end
         end
         exp_done = (drop_at >= 0) ? (j == M + 2) : (j >= M + 2);
         check($sformatf("%s done c%0d", name, j), 64'(bus.done), 64'(exp_done));
      end
      check($sformatf("%s write count", name), 64'(nwr), 64'(M));
      if (drop_at < 0) begin
         @(negedge clk);
         bus.start = 1'b0;
         check($sformatf("%s done before drop", name), 64'(bus.done), 64'd1);
         @(negedge clk);
         check($sformatf("%s done after drop", name), 64'(bus.done), 64'd0);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int extra;
      bus.start = 1'b0;
      for (int i = 0; i < M; i++) begin
         m01[i] = '0; m11[i] = '0; m02[i] = '0; m12[i] = '0;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset rd_addr", 64'(bus.rd_addr), 64'd0);
      check("reset wr_addr", 64'(bus.wr_addr), 64'd0);
      check("reset wr_en", 64'(bus.wr_en), 64'd0);
      check("reset c0_wdata", 64'(bus.c0_wdata), 64'd0);
      check("reset c1_wdata", 64'(bus.c1_wdata), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      reset = 1'b0;

      // Directed edge vectors on c0 (and c1 at address 0), random c1 elsewhere.
      fill_random();
      m01[0] = 5;  m02[0] = 3;  m11[0] = 5;  m12[0] = 3;
      m01[1] = 3;  m02[1] = 5;
      m01[2] = 16; m02[2] = 16;
      m01[3] = 16; m02[3] = 0;
      m01[4] = 0;  m02[4] = 96;
      m01[5] = 96; m02[5] = 0;
      run_op("directed", -1, 20);

      fill_random();
      run_op("early_drop", 1, 2);

      // Reset lands at the edge ending RUN cycle 3.
      fill_random();
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      for (int j = 0; j < 4; j++) @(negedge clk);
      reset = 1'b1;
      bus.start = 1'b0;
      @(negedge clk);
      check("midrst wr_en", 64'(bus.wr_en), 64'd0);
      check("midrst done", 64'(bus.done), 64'd0);
      check("midrst state", 64'(dut.state), 64'(IDLE));
      reset = 1'b0;
      extra = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (bus.wr_en) extra++;
      end
      check("midrst no writes", 64'(extra), 64'd0);

      fill_random();
      run_op("after_reset", -1, 3);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
